csr_file: RTL and testbench

//  Machine-mode CSR register file; execution end of the CSR path fed by csr_decoder.

---
 rtl/csr_file_if.sv | 44 ++++
 rtl/csr_file.sv | 147 ++++++++++++++
 tb/tb_csr_file.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/csr_file_if.sv
// rtl/csr_file_if.sv - CSR access bus between writeback and the machine-mode CSR file
// Carries the RMW request from the decoder side and the combinational read/illegal response.
`ifndef CSR_NA
`define CSR_NA    2'b00
`endif
`ifndef CSR_PASS
`define CSR_PASS  2'b01
`endif
`ifndef CSR_SET
`define CSR_SET   2'b10
`endif
`ifndef CSR_CLEAR
`define CSR_CLEAR 2'b11
`endif
`ifndef CSR_SRC_REG
`define CSR_SRC_REG 1'b0
`endif
`ifndef CSR_SRC_IMM
`define CSR_SRC_IMM 1'b1
`endif

interface csr_file_if;
  logic        csr_en_i;
  logic [1:0]  csr_control_i;
  logic        csr_src_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_rs1_data_i;
  logic [4:0]  csr_uimm_i;
  logic        instr_retired_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;

  modport master (
    output csr_en_i, csr_control_i, csr_src_i, csr_addr_i,
           csr_rs1_data_i, csr_uimm_i, instr_retired_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_en_i, csr_control_i, csr_src_i, csr_addr_i,
           csr_rs1_data_i, csr_uimm_i, instr_retired_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR register file with single-cycle atomic read-modify-write
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters and their user shadows.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic      clk_i,
  input  logic      reset_i,
  csr_file_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:2] r_mepc;
  logic [31:0] r_mcause;

  logic [31:0] w_rdata;
  logic        w_impl;
  logic [31:0] w_op;
  logic [31:0] w_new;
  logic        w_is_pass;
  logic        w_is_rmw;
  logic        w_wants_write;
  logic        w_illegal;
  logic        w_we;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
`else
  logic        w_unused_retire;
  assign w_unused_retire = bus.instr_retired_i;
`endif

  // Read mux doubles as the implemented-address decode.
  always_comb begin
    w_rdata = 32'h0;
    w_impl  = 1'b1;
    case (bus.csr_addr_i)
      ADDR_MSTATUS:  w_rdata = {24'h0, r_mpie, 3'b000, r_mie, 3'b000};
      ADDR_MTVEC:    w_rdata = r_mtvec;
      ADDR_MSCRATCH: w_rdata = r_mscratch;
      ADDR_MEPC:     w_rdata = {r_mepc, 2'b00};
      ADDR_MCAUSE:   w_rdata = r_mcause;
      ADDR_MHARTID:  w_rdata = MHARTID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,    ADDR_CYCLE:    w_rdata = r_mcycle[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   w_rdata = r_mcycle[63:32];
      ADDR_MINSTRET,  ADDR_INSTRET:  w_rdata = r_minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: w_rdata = r_minstret[63:32];
`endif
      default:       w_impl  = 1'b0;
    endcase
  end

  assign w_op = (bus.csr_src_i == `CSR_SRC_IMM) ? {27'h0, bus.csr_uimm_i} : bus.csr_rs1_data_i;

  always_comb begin
    w_new = w_op;
    case (bus.csr_control_i)
      `CSR_SET:   w_new = w_rdata | w_op;
      `CSR_CLEAR: w_new = w_rdata & ~w_op;
      default:    w_new = w_op;
    endcase
  end

  // SET/CLEAR with a zero rs1 index or zimm is a pure read, so it is legal even on RO CSRs.
  assign w_is_pass     = (bus.csr_control_i == `CSR_PASS);
  assign w_is_rmw      = (bus.csr_control_i == `CSR_SET) || (bus.csr_control_i == `CSR_CLEAR);
  assign w_wants_write = bus.csr_en_i && (w_is_pass || (w_is_rmw && (bus.csr_uimm_i != 5'd0)));
  assign w_illegal     = bus.csr_en_i &&
                         (!w_impl || ((bus.csr_addr_i[11:10] == 2'b11) && w_wants_write));
  assign w_we          = w_wants_write && !w_illegal;

  assign bus.csr_rdata_o   = w_rdata;
  assign bus.csr_illegal_o = w_illegal;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= MTVEC_RESET & ~32'h2;
      r_mscratch <= 32'h0;
      r_mepc     <= 30'h0;
      r_mcause   <= 32'h0;
    end else if (w_we) begin
      case (bus.csr_addr_i)
        ADDR_MSTATUS: begin
          r_mie  <= w_new[3];
          r_mpie <= w_new[7];
        end
        ADDR_MTVEC:    r_mtvec    <= w_new & ~32'h2;
        ADDR_MSCRATCH: r_mscratch <= w_new;
        ADDR_MEPC:     r_mepc     <= w_new[31:2];
        ADDR_MCAUSE:   r_mcause   <= w_new;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half replaces that half and freezes the other for the cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mcycle <= 64'h0;
    end else if (w_we && (bus.csr_addr_i == ADDR_MCYCLE)) begin
      r_mcycle[31:0] <= w_new;
    end else if (w_we && (bus.csr_addr_i == ADDR_MCYCLEH)) begin
      r_mcycle[63:32] <= w_new;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_minstret <= 64'h0;
    end else if (w_we && (bus.csr_addr_i == ADDR_MINSTRET)) begin
      r_minstret[31:0] <= w_new;
    end else if (w_we && (bus.csr_addr_i == ADDR_MINSTRETH)) begin
      r_minstret[63:32] <= w_new;
    end else if (bus.instr_retired_i) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - scoreboard bench for csr_file
// Counter checks are compiled in when CSR_COUNTERS_EN is defined.
module tb_csr_file;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  csr_file_if bus();

  csr_file #(
    .MTVEC_RESET(32'h0000_0100),
    .MHARTID    (32'h0000_0005)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        sample = 1'b0;
  logic [63:0] m_cyc;

  // Free-running cycle reference, valid until the bench writes mcycle.
  always @(posedge clk_i) begin
    if (reset_i) m_cyc <= 64'h0;
    else         m_cyc <= m_cyc + 64'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (sample) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, ".rdata"}, bus.csr_rdata_o, mon_e.rdata);
        check({mon_e.tag, ".ill"}, {31'h0, bus.csr_illegal_o}, {31'h0, mon_e.ill});
      end
    end
  end

  task automatic op(input string tag, input logic en, input logic [1:0] ctrl, input logic src,
                    input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] uimm,
                    input logic retire, input logic [31:0] er, input logic ei);
    exp_t e;
    bus.csr_en_i        = en;
    bus.csr_control_i   = ctrl;
    bus.csr_src_i       = src;
    bus.csr_addr_i      = addr;
    bus.csr_rs1_data_i  = rs1;
    bus.csr_uimm_i      = uimm;
    bus.instr_retired_i = retire;
    e.tag   = tag;
    e.rdata = er;
    e.ill   = ei;
    sb_q.push_back(e);
    sample = 1'b1;
    @(posedge clk_i);
    #1;
    sample = 1'b0;
    bus.csr_en_i        = 1'b0;
    bus.instr_retired_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] er);
    op(tag, 1'b0, `CSR_NA, `CSR_SRC_REG, addr, 32'h0, 5'd0, 1'b0, er, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.csr_en_i        = 1'b0;
    bus.csr_control_i   = `CSR_NA;
    bus.csr_src_i       = `CSR_SRC_REG;
    bus.csr_addr_i      = 12'h0;
    bus.csr_rs1_data_i  = 32'h0;
    bus.csr_uimm_i      = 5'd0;
    bus.instr_retired_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    rd("rst_mtvec",    12'h305, 32'h0000_0100);
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("rst_mstatus",  12'h300, 32'h0);
    rd("rst_mepc",     12'h341, 32'h0);

    op("ms_pass", 1'b1, `CSR_PASS,  `CSR_SRC_REG, 12'h340, 32'hDEAD_BEEF, 5'd1,    1'b0, 32'h0,         1'b0);
    op("ms_set",  1'b1, `CSR_SET,   `CSR_SRC_IMM, 12'h340, 32'hFFFF_FFFF, 5'h10,   1'b0, 32'hDEAD_BEEF, 1'b0);
    op("ms_clr",  1'b1, `CSR_CLEAR, `CSR_SRC_REG, 12'h340, 32'h0000_FFFF, 5'd1,    1'b0, 32'hDEAD_BEFF, 1'b0);
    rd("ms_final", 12'h340, 32'hDEAD_0000);
    op("ms_clr0", 1'b1, `CSR_CLEAR, `CSR_SRC_REG, 12'h340, 32'hFFFF_FFFF, 5'd0,    1'b0, 32'hDEAD_0000, 1'b0);
    op("ms_na",   1'b1, `CSR_NA,    `CSR_SRC_REG, 12'h340, 32'h1234_5678, 5'd3,    1'b0, 32'hDEAD_0000, 1'b0);
    rd("ms_kept", 12'h340, 32'hDEAD_0000);

`ifdef CSR_COUNTERS_EN
    op("c00_set0", 1'b1, `CSR_SET,  `CSR_SRC_REG, 12'hC00, 32'hFFFF_FFFF, 5'd0, 1'b0, m_cyc[31:0], 1'b0);
    op("c00_pass", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hC00, 32'h0,         5'd2, 1'b0, m_cyc[31:0], 1'b1);
    rd("c00_kept", 12'hC00, m_cyc[31:0]);
`else
    op("c00_set0", 1'b1, `CSR_SET,  `CSR_SRC_REG, 12'hC00, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0, 1'b1);
    op("c00_pass", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hC00, 32'h0,         5'd2, 1'b0, 32'h0, 1'b1);
    op("b00_pass", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hB00, 32'h7,         5'd2, 1'b0, 32'h0, 1'b1);
`endif
    op("unimpl_7c0", 1'b1, `CSR_SET,  `CSR_SRC_REG, 12'h7C0, 32'h0, 5'd0, 1'b0, 32'h0,         1'b1);
    op("hart_rd",    1'b1, `CSR_SET,  `CSR_SRC_IMM, 12'hF14, 32'h0, 5'd0, 1'b0, 32'h0000_0005, 1'b0);
    op("hart_wr",    1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hF14, 32'h9, 5'd1, 1'b0, 32'h0000_0005, 1'b1);
    rd("hart_kept", 12'hF14, 32'h0000_0005);

`ifdef CSR_COUNTERS_EN
    op("mcyc_lo", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hB00, 32'hFFFF_FFFE, 5'd1, 1'b0, m_cyc[31:0], 1'b0);
    op("mcyc_hi", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hB80, 32'h0,         5'd1, 1'b0, 32'h0,       1'b0);
    rd("mcyc_t0",  12'hB00, 32'hFFFF_FFFE);
    rd("mcyc_t1",  12'hB00, 32'hFFFF_FFFF);
    rd("mcych_t2", 12'hB80, 32'h0000_0001);
    rd("mcyc_t3",  12'hB00, 32'h0000_0001);
    rd("cych_t4",  12'hC80, 32'h0000_0001);

    op("mret_wr", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'hB02, 32'h0000_0050, 5'd1, 1'b1, 32'h0, 1'b0);
    op("mret_rt", 1'b0, `CSR_NA,   `CSR_SRC_REG, 12'hB02, 32'h0,         5'd0, 1'b1, 32'h0000_0050, 1'b0);
    rd("iret_51",  12'hC02, 32'h0000_0051);
    rd("ireth_0",  12'hC82, 32'h0);
    rd("iret_hold", 12'hC02, 32'h0000_0051);
`endif

    op("mepc_wr", 1'b1, `CSR_PASS, `CSR_SRC_REG, 12'h341, 32'h0000_1003, 5'd1, 1'b0, 32'h0, 1'b0);
    rd("mepc_rd", 12'h341, 32'h0000_1000);
    op("mst_wr",  1'b1, `CSR_PASS, `CSR_SRC_REG, 12'h300, 32'hFFFF_FFFF, 5'd1, 1'b0, 32'h0, 1'b0);
    rd("mst_rd",  12'h300, 32'h0000_0088);
    op("mst_clr", 1'b1, `CSR_CLEAR, `CSR_SRC_IMM, 12'h300, 32'h0, 5'h08, 1'b0, 32'h0000_0088, 1'b0);
    rd("mst_rd2", 12'h300, 32'h0000_0080);
    op("mtv_wr",  1'b1, `CSR_PASS, `CSR_SRC_REG, 12'h305, 32'hFFFF_FFFF, 5'd1, 1'b0, 32'h0000_0100, 1'b0);
    rd("mtv_rd",  12'h305, 32'hFFFF_FFFD);
    op("mca_wr",  1'b1, `CSR_PASS, `CSR_SRC_REG, 12'h342, 32'h8000_000B, 5'd1, 1'b0, 32'h0, 1'b0);
    rd("mca_rd",  12'h342, 32'h8000_000B);

    bus.csr_en_i       = 1'b1;
    bus.csr_control_i  = `CSR_PASS;
    bus.csr_src_i      = `CSR_SRC_REG;
    bus.csr_addr_i     = 12'h340;
    bus.csr_rs1_data_i = 32'h1234_5678;
    bus.csr_uimm_i     = 5'd1;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    bus.csr_en_i = 1'b0;

    rd("rr_mscratch", 12'h340, 32'h0);
    rd("rr_mtvec",    12'h305, 32'h0000_0100);
    rd("rr_mepc",     12'h341, 32'h0);
`ifdef CSR_COUNTERS_EN
    rd("rr_mcycle",   12'hB00, m_cyc[31:0]);
`endif

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
